// File: rtl/lut_rd_pkg.sv
// lut_rd_pkg
// Shared definitions for the LUT sweep readback engine:
//   - rd_state_e       : sweep controller states
//   - samples_per_word : number of LUT results packed into one output word
//   - words_per_sweep  : number of output words produced by one full sweep
//   - params_legal     : parameter-set sanity check used at elaboration
package lut_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    // Whole samples per word; any leftover high bits of a word stay 0.
    function automatic int unsigned samples_per_word(input int unsigned out_bits,
                                                     input int unsigned word_w);
        return word_w / out_bits;
    endfunction

    // Ceiling of (2^in_bits codes) / (samples per word).
    function automatic int unsigned words_per_sweep(input int unsigned in_bits,
                                                    input int unsigned out_bits,
                                                    input int unsigned word_w);
        int unsigned spw;
        int unsigned codes;
        spw   = samples_per_word(out_bits, word_w);
        codes = 32'd1 << in_bits;
        return (codes + spw - 32'd1) / spw;
    endfunction

    // Code counter must stay comfortably inside 32-bit arithmetic and at
    // least one sample has to fit in a word.
    function automatic bit params_legal(input int unsigned in_bits,
                                        input int unsigned out_bits,
                                        input int unsigned word_w);
        return (in_bits >= 32'd1) && (in_bits <= 32'd20) &&
               (out_bits >= 32'd1) && (out_bits <= word_w);
    endfunction

endpackage

// File: rtl/lut_rd_pack.sv
// lut_rd_pack
// Packs LUT samples into words and holds one finished word for the consumer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : synchronous flush (abort); wins over everything
//   clear        : sweep start; empties the pack register and slot index
//   sample_en    : controller wants to take a sample this cycle
//   sample_last  : the offered sample is the final code of the sweep
//   sample_data  : LUT result for the current code
//   sample_take  : the sample is taken (not stalled) this cycle
//   out_ready    : consumer accepts when out_valid && out_ready
//   last_fire    : the out_last word is accepted this cycle
//   out_data/out_valid/out_last : registered output word and flags
module lut_rd_pack
    import lut_rd_pkg::*;
#(
    parameter int unsigned OUT_BITS = 1,
    parameter int unsigned WORD_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                clear,
    input  logic                sample_en,
    input  logic                sample_last,
    input  logic [OUT_BITS-1:0] sample_data,
    input  logic                out_ready,
    output logic                sample_take,
    output logic                last_fire,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_valid,
    output logic                out_last
);

    localparam int unsigned SPW   = samples_per_word(OUT_BITS, WORD_W);
    localparam int unsigned IDX_W = $clog2(SPW) + 1;

    logic [IDX_W-1:0]  idx_r;
    logic [WORD_W-1:0] pack_r;
    logic [WORD_W-1:0] word_s;
    logic [WORD_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic              complete_s;
    logic              can_load_s;
    logic              fire_s;
    logic              take_s;

    // Pack register with the current sample merged into slot idx_r.
    always_comb begin
        word_s = pack_r;
        for (int unsigned i = 0; i < SPW; i++) begin
            word_s[i*OUT_BITS +: OUT_BITS] = (idx_r == IDX_W'(i)) ?
                sample_data : pack_r[i*OUT_BITS +: OUT_BITS];
        end
    end

    // A word finishes on its last slot or on the final code; it can only
    // leave if the output register is empty or draining this very cycle.
    assign complete_s  = (idx_r == IDX_W'(SPW - 1)) || sample_last;
    assign fire_s      = out_valid_r && out_ready;
    assign can_load_s  = !out_valid_r || out_ready;
    assign take_s      = sample_en && (!complete_s || can_load_s);
    assign sample_take = take_s;
    assign last_fire   = fire_s && out_last_r;

    // Slot index and partially filled word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r  <= {IDX_W{1'b0}};
            pack_r <= {WORD_W{1'b0}};
        end else if (flush || clear) begin
            idx_r  <= {IDX_W{1'b0}};
            pack_r <= {WORD_W{1'b0}};
        end else if (take_s && complete_s) begin
            idx_r  <= {IDX_W{1'b0}};
            pack_r <= {WORD_W{1'b0}};
        end else if (take_s) begin
            idx_r  <= idx_r + IDX_W'(1);
            pack_r <= word_s;
        end else begin
            idx_r  <= idx_r;
            pack_r <= pack_r;
        end
    end

    // Single-entry output register; contents frozen while valid && !ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {WORD_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (flush) begin
            out_data_r  <= {WORD_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (take_s && complete_s) begin
            out_data_r  <= word_s;
            out_valid_r <= 1'b1;
            out_last_r  <= sample_last;
        end else if (fire_s) begin
            out_data_r  <= out_data_r;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_data_r  <= out_data_r;
            out_valid_r <= out_valid_r;
            out_last_r  <= out_last_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;

endmodule

// File: rtl/lut_sweep_reader.sv
// lut_sweep_reader
// Sweeps every input code through a combinational LUT and streams the packed
// results out on a valid/ready interface.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse, begins a sweep when idle
//   abort      : synchronous flush back to idle, highest priority
//   lut_in     : code driven to the LUT under test (registered counter)
//   lut_out    : LUT result for lut_in
//   out_data, out_valid, out_ready, out_last : packed result stream
//   busy       : sweep in progress
//   done       : one-cycle pulse after the final word is accepted
module lut_sweep_reader
    import lut_rd_pkg::*;
#(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 1,
    parameter int unsigned WORD_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic [IN_BITS-1:0]  lut_in,
    input  logic [OUT_BITS-1:0] lut_out,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CODE_W = IN_BITS + 1;
    localparam logic [CODE_W-1:0] LAST_CODE = {1'b0, {IN_BITS{1'b1}}};

    if (!params_legal(IN_BITS, OUT_BITS, WORD_W)) begin : g_illegal_params
        $error("lut_sweep_reader: illegal IN_BITS/OUT_BITS/WORD_W combination");
    end

    rd_state_e         state_r;
    rd_state_e         state_next_s;
    logic [CODE_W-1:0] code_r;
    logic [CODE_W-1:0] code_next_s;
    logic              busy_r;
    logic              done_r;
    logic              clear_s;
    logic              sample_en_s;
    logic              sample_take_s;
    logic              last_fire_s;
    logic              last_code_s;

    assign last_code_s = (code_r == LAST_CODE);
    assign sample_en_s = (state_r == ST_SWEEP) && !abort;
    assign clear_s     = (state_r == ST_IDLE) && start && !abort;

    // Next-state and code-counter logic; abort overrides every state.
    always_comb begin
        state_next_s = state_r;
        code_next_s  = code_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_SWEEP;
                    code_next_s  = {CODE_W{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (sample_take_s) begin
                    code_next_s = code_r + CODE_W'(1);
                    if (last_code_s) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_SWEEP;
                    end
                end else begin
                    state_next_s = ST_SWEEP;
                end
            end
            ST_DRAIN: begin
                if (last_fire_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                code_next_s  = {CODE_W{1'b0}};
            end
        endcase
        if (abort) begin
            state_next_s = ST_IDLE;
            code_next_s  = {CODE_W{1'b0}};
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State, code counter and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            code_r  <= {CODE_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            code_r  <= code_next_s;
            busy_r  <= (state_next_s == ST_SWEEP) || (state_next_s == ST_DRAIN);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    lut_rd_pack #(
        .OUT_BITS (OUT_BITS),
        .WORD_W   (WORD_W)
    ) u_pack (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (abort),
        .clear       (clear_s),
        .sample_en   (sample_en_s),
        .sample_last (last_code_s),
        .sample_data (lut_out),
        .out_ready   (out_ready),
        .sample_take (sample_take_s),
        .last_fire   (last_fire_s),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last)
    );

    // The low code bits drive the LUT; the extra MSB only marks sweep end.
    assign lut_in = code_r[IN_BITS-1:0];
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_lut_sweep_reader.sv
// tb_lut_sweep_reader
// Self-checking bench: table of sweep configurations with a word scoreboard,
// plus hand-written sequences for abort, mid-drain reset and a narrow config.
module tb_lut_sweep_reader;
    import lut_rd_pkg::*;

    localparam int NW = int'(words_per_sweep(32'd8, 32'd1, 32'd32));

    logic        clk = 1'b0;
    logic        rst_n, start, abort, out_ready;
    logic [7:0]  lut_in;
    logic        lut_out;
    logic [31:0] out_data;
    logic        out_valid, out_last, busy, done;
    int          lut_mode;

    logic        start6, ready6, abort6;
    logic [3:0]  lut_in6;
    logic [2:0]  lut_out6;
    logic [31:0] out_data6;
    logic        out_valid6, out_last6, busy6, done6;

    typedef struct { logic [31:0] data; logic last; } exp_t;
    typedef struct { int mode; bit rnd; bit timing; } vec_t;
    typedef struct { int mode; int word; logic [31:0] data; } spot_t;

    exp_t        exp_q[$];
    logic [31:0] recv [0:7];
    int          recv_n;
    int          checks, errors;
    logic        mon_en;
    logic        hold_p, stall_p, busy_p, last_p;
    logic [31:0] data_p;
    logic [7:0]  lut_p;

    always #5 clk = ~clk;

    function automatic logic lut_model(input int mode, input logic [7:0] code);
        case (mode)
            0:       return (code == 8'hA5);
            1:       return code[0];
            default: return ^code;
        endcase
    endfunction

    function automatic logic [2:0] lut6_model(input logic [3:0] code);
        return {code[0], code[3:2]} ^ 3'b010;
    endfunction

    assign lut_out  = lut_model(lut_mode, lut_in);
    assign lut_out6 = lut6_model(lut_in6);

    lut_sweep_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .lut_in(lut_in), .lut_out(lut_out), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    lut_sweep_reader #(.IN_BITS(4), .OUT_BITS(3), .WORD_W(32)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .abort(abort6),
        .lut_in(lut_in6), .lut_out(lut_out6), .out_data(out_data6),
        .out_valid(out_valid6), .out_ready(ready6), .out_last(out_last6),
        .busy(busy6), .done(done6)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard pop on each handshake plus stability / stall checks.
    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_p) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", out_data, data_p);
                check("hold_last", {31'd0, out_last}, {31'd0, last_p});
            end
            if (stall_p) check("stall_lut_in", {24'd0, lut_in}, {24'd0, lut_p});
            if (busy_p && busy && lut_p != 8'hFF)
                check("lut_in_step", {31'd0, (lut_in == lut_p) || (lut_in == lut_p + 8'd1)}, 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_data, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_data", out_data, e.data);
                    check("word_last", {31'd0, out_last}, {31'd0, e.last});
                end
                if (recv_n < 8) recv[recv_n] <= out_data;
                recv_n <= recv_n + 1;
            end
            hold_p  <= out_valid && !out_ready && !abort;
            data_p  <= out_data;
            last_p  <= out_last;
            stall_p <= busy && out_valid && !out_ready && !abort && (lut_in[4:0] == 5'd31);
            lut_p   <= lut_in;
            busy_p  <= busy && !abort;
        end else begin
            hold_p  <= 1'b0;
            stall_p <= 1'b0;
            busy_p  <= 1'b0;
        end
    end

    task automatic push_expected(input int mode);
        exp_t       e;
        logic [7:0] c;
        for (int w = 0; w < NW; w++) begin
            e.data = 32'd0;
            for (int s = 0; s < 32; s++) begin
                c = 8'(w * 32 + s);
                e.data[s] = lut_model(mode, c);
            end
            e.last = (w == NW - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(input int mode, input bit rnd, input bit timing);
        int cyc;
        bit seen;
        lut_mode = mode;
        recv_n   = 0;
        push_expected(mode);
        out_ready = 1'b1;
        pulse_start();
        cyc  = 1;
        seen = 1'b0;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            if (timing) begin
                check("t_busy", {31'd0, busy}, {31'd0, (cyc >= 1 && cyc <= 257)});
                check("t_done", {31'd0, done}, {31'd0, (cyc == 258)});
                check("t_valid", {31'd0, out_valid},
                      {31'd0, (cyc >= 33 && cyc <= 257 && ((cyc - 33) % 32 == 0))});
                check("t_last", {31'd0, out_last}, {31'd0, (cyc == 257)});
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (timing) check("done_cycle", cyc, 32'd258);
        check("words_left", exp_q.size(), 32'd0);
        check("word_count", recv_n, NW);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("done_pulse_end", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    vec_t  vecs[4];
    spot_t spots[6];

    initial begin
        int          n;
        int          n6;
        bit          seen6;
        logic [31:0] w6 [0:1];
        logic        l6 [0:1];
        logic [31:0] e6;
        logic [3:0]  c6;

        vecs[0]  = '{mode: 0, rnd: 1'b0, timing: 1'b1};
        vecs[1]  = '{mode: 1, rnd: 1'b0, timing: 1'b1};
        vecs[2]  = '{mode: 0, rnd: 1'b1, timing: 1'b0};
        vecs[3]  = '{mode: 2, rnd: 1'b1, timing: 1'b0};
        spots[0] = '{mode: 0, word: 5, data: 32'h0000_0020};
        spots[1] = '{mode: 0, word: 0, data: 32'h0000_0000};
        spots[2] = '{mode: 0, word: 7, data: 32'h0000_0000};
        spots[3] = '{mode: 1, word: 0, data: 32'hAAAA_AAAA};
        spots[4] = '{mode: 1, word: 4, data: 32'hAAAA_AAAA};
        spots[5] = '{mode: 1, word: 7, data: 32'hAAAA_AAAA};

        checks = 0; errors = 0; recv_n = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start6 = 1'b0; ready6 = 1'b1; abort6 = 1'b0;
        mon_en = 1'b0; lut_mode = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_lut_in", {24'd0, lut_in}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst6_valid", {31'd0, out_valid6}, 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Table of full sweeps, then spot checks on received words.
        for (int v = 0; v < 4; v++) begin
            run_sweep(vecs[v].mode, vecs[v].rnd, vecs[v].timing);
            for (int k = 0; k < 6; k++)
                if (spots[k].mode == vecs[v].mode)
                    check("spot_word", recv[spots[k].word], spots[k].data);
        end

        // Abort during a stall with start in the same cycle.
        lut_mode = 0; recv_n = 0;
        push_expected(0);
        out_ready = 1'b1;
        pulse_start();
        n = 0;
        while (recv_n < 3 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        n = 0;
        while (lut_in != 8'd159 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("stall_lut_hold", {24'd0, lut_in}, 32'd159);
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_last", {31'd0, out_last}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_lut_in", {24'd0, lut_in}, 32'd0);
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_abort_done", {31'd0, done}, 32'd0);
            check("post_abort_busy", {31'd0, busy}, 32'd0);
        end
        out_ready = 1'b1;
        run_sweep(0, 1'b0, 1'b1);
        check("after_abort_w5", recv[5], 32'h0000_0020);

        // Asynchronous reset while waiting in DRAIN.
        lut_mode = 1; recv_n = 0;
        push_expected(1);
        out_ready = 1'b1;
        pulse_start();
        repeat (240) @(posedge clk);
        #1;
        out_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_last) && n < 100);
        check("drain_last_seen", {31'd0, out_last}, 32'd1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_lut_in", {24'd0, lut_in}, 32'd0);
        check("arst_data", out_data, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_last", {31'd0, out_last}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        run_sweep(1, 1'b0, 1'b1);

        // Narrow configuration: 3-bit results, 10 per word, 2 words.
        @(posedge clk); #1;
        start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        n6 = 0; seen6 = 1'b0; n = 0;
        while (!seen6 && n < 100) begin
            @(negedge clk);
            if (out_valid6 && ready6) begin
                if (n6 < 2) begin
                    w6[n6] = out_data6;
                    l6[n6] = out_last6;
                end
                n6++;
            end
            if (done6) seen6 = 1'b1;
            n++;
        end
        check("n6_done", {31'd0, seen6}, 32'd1);
        check("n6_words", n6, int'(words_per_sweep(32'd4, 32'd3, 32'd32)));
        for (int w = 0; w < 2; w++) begin
            e6 = 32'd0;
            for (int s = 0; s < 10; s++) begin
                if (w * 10 + s < 16) begin
                    c6 = 4'(w * 10 + s);
                    e6[s*3 +: 3] = lut6_model(c6);
                end
            end
            check("n6_data", w6[w], e6);
            check("n6_last", {31'd0, l6[w]}, {31'd0, (w == 1)});
        end
        check("n6_w1_high_zero", {18'd0, w6[1][31:18]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
